// File: rtl/frame_color_classifier_pkg.sv
// rtl/frame_color_classifier_pkg.sv - shared codes, frame geometry and FSM states
//
// Purpose: constants and types shared by the frame colour classifier and the
//          raster address generator.
// Contents:
//   COL_*  : 2-bit reported colour codes
//   PIX_*  : 3-bit {R,G,B} pure-colour pixel codes
//   QCIF_* : default frame geometry
//   state_t: classifier FSM state encoding
package frame_color_classifier_pkg;

  localparam logic [1:0] COL_NONE  = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [1:0] COL_BLUE  = 2'b11;

  localparam logic [2:0] PIX_R = 3'b100;
  localparam logic [2:0] PIX_G = 3'b010;
  localparam logic [2:0] PIX_B = 3'b001;

  localparam int QCIF_W      = 176;
  localparam int QCIF_H      = 144;
  localparam int QCIF_PIXELS = QCIF_W * QCIF_H;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    DECIDE = 2'd3
  } state_t;

endpackage

// File: rtl/frame_color_classifier_pixel_raster_counter.sv
// rtl/frame_color_classifier_pixel_raster_counter.sv - raster address generator with window flag
//
// Purpose: walks a frame buffer in raster order, tracking column/row of the
//          address currently presented, and flags addresses inside a window.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart at address 0 / column 0 / row 0
//   advance   : step to the next pixel (holds once the last pixel is reached)
//   addr      : current buffer address
//   in_window : current pixel lies inside [WIN_X0..WIN_X1] x [WIN_Y0..WIN_Y1]
//   last      : current address is the final pixel of the frame
module pixel_raster_counter #(
  parameter int AW     = 15,
  parameter int IMG_W  = 176,
  parameter int IMG_H  = 144,
  parameter int WIN_X0 = 48,
  parameter int WIN_X1 = 127,
  parameter int WIN_Y0 = 32,
  parameter int WIN_Y1 = 111
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          in_window,
  output logic          last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign last = (addr == LAST_ADDR);

  // Bounds are compared as full integers so an inverted window (X1 < X0)
  // simply never matches.
  assign in_window = (int'(col) >= WIN_X0) && (int'(col) <= WIN_X1) &&
                     (int'(row) >= WIN_Y0) && (int'(row) <= WIN_Y1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (clear) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (advance && !last) begin
      addr <= addr + 1'b1;
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_color_classifier.sv
// rtl/frame_color_classifier.sv - counts pure R/G/B pixels in a window and reports the dominant colour
//
// Purpose: on each rising edge of frame_ready, scans the frame buffer once,
//          counts pure-red/green/blue pixels inside the window and reports
//          the winning colour if its count reaches THRESH.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   frame_ready       : capture stage "frame complete" level
//   rd_data / rd_addr : buffer read port, data valid one clk after address
//   busy              : scan in progress (start through DECIDE)
//   result_valid      : one-cycle pulse when color/counts update
//   color             : 00 none, 01 red, 10 green, 11 blue
//   cnt_r/cnt_g/cnt_b : counts of the last completed scan
module frame_color_classifier
  import frame_color_classifier_pkg::*;
#(
  parameter int AW     = 15,
  parameter int IMG_W  = QCIF_W,
  parameter int IMG_H  = QCIF_H,
  parameter int WIN_X0 = 48,
  parameter int WIN_X1 = 127,
  parameter int WIN_Y0 = 32,
  parameter int WIN_Y1 = 111,
  parameter int THRESH = 1600
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_ready,
  input  logic [2:0]    rd_data,
  output logic [AW-1:0] rd_addr,
  output logic          busy,
  output logic          result_valid,
  output logic [1:0]    color,
  output logic [AW-1:0] cnt_r,
  output logic [AW-1:0] cnt_g,
  output logic [AW-1:0] cnt_b
);

  localparam logic [AW-1:0] ACC_MAX = '1;

  state_t        state, state_next;
  logic          frame_ready_q;
  logic          start;
  logic          clear, advance;
  logic          in_window, last;
  logic          win_q, valid_q;
  logic [AW-1:0] acc_r, acc_g, acc_b;
  logic [1:0]    win_color;
  logic [AW-1:0] win_max;

  assign start = frame_ready & ~frame_ready_q;

  pixel_raster_counter #(
    .AW(AW), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .WIN_X0(WIN_X0), .WIN_X1(WIN_X1), .WIN_Y0(WIN_Y0), .WIN_Y1(WIN_Y1)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .advance  (advance),
    .addr     (rd_addr),
    .in_window(in_window),
    .last     (last)
  );

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear      = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        advance = 1'b1;
        if (last) state_next = DRAIN;
      end
      DRAIN:   state_next = DECIDE;
      DECIDE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strict greater-than lets an earlier colour keep a tie: red > green > blue.
  always_comb begin
    win_color = COL_RED;
    win_max   = acc_r;
    if (acc_g > win_max) begin
      win_color = COL_GREEN;
      win_max   = acc_g;
    end
    if (acc_b > win_max) begin
      win_color = COL_BLUE;
      win_max   = acc_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      frame_ready_q <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      color         <= COL_NONE;
      cnt_r         <= '0;
      cnt_g         <= '0;
      cnt_b         <= '0;
      acc_r         <= '0;
      acc_g         <= '0;
      acc_b         <= '0;
      win_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state         <= state_next;
      frame_ready_q <= frame_ready;
      result_valid  <= 1'b0;
      // Window flag and data-valid follow the issued address by one cycle
      // so they line up with rd_data.
      win_q         <= in_window;
      valid_q       <= (state == SCAN);

      if (clear) begin
        acc_r <= '0;
        acc_g <= '0;
        acc_b <= '0;
        busy  <= 1'b1;
      end else if (valid_q && win_q) begin
        case (rd_data)
          PIX_R:   if (acc_r != ACC_MAX) acc_r <= acc_r + 1'b1;
          PIX_G:   if (acc_g != ACC_MAX) acc_g <= acc_g + 1'b1;
          PIX_B:   if (acc_b != ACC_MAX) acc_b <= acc_b + 1'b1;
          default: ;
        endcase
      end

      if (state == DECIDE) begin
        cnt_r        <= acc_r;
        cnt_g        <= acc_g;
        cnt_b        <= acc_b;
        color        <= (int'(win_max) >= THRESH) ? win_color : COL_NONE;
        result_valid <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_color_classifier.sv
// tb/tb_frame_color_classifier.sv - directed bench for frame_color_classifier
module tb_frame_color_classifier;
  import frame_color_classifier_pkg::*;

  // Reduced frame for most scenarios: 16x12 pixels, window cols 4..11, rows 3..8 (48 px)
  localparam int S_W   = 16;
  localparam int S_H   = 12;
  localparam int S_N   = S_W * S_H;
  localparam int S_LAT = S_N + 2;
  localparam int B_N   = 25344;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       frame_ready;
  logic [2:0] rd_data;
  logic [7:0] rd_addr;
  logic       busy, result_valid;
  logic [1:0] color;
  logic [7:0] cnt_r, cnt_g, cnt_b;

  logic        fr_big;
  logic [2:0]  rd_data_big;
  logic [14:0] rd_addr_big;
  logic        busy_big, rv_big;
  logic [1:0]  color_big;
  logic [14:0] cnt_r_big, cnt_g_big, cnt_b_big;

  logic [2:0] mem_s [S_N];
  logic [2:0] mem_b [B_N];

  int vectors    = 0;
  int miscompares = 0;

  frame_color_classifier #(
    .AW(8), .IMG_W(S_W), .IMG_H(S_H),
    .WIN_X0(4), .WIN_X1(11), .WIN_Y0(3), .WIN_Y1(8), .THRESH(12)
  ) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready), .rd_data(rd_data),
    .rd_addr(rd_addr), .busy(busy), .result_valid(result_valid), .color(color),
    .cnt_r(cnt_r), .cnt_g(cnt_g), .cnt_b(cnt_b)
  );

  frame_color_classifier dut_qcif (
    .clk(clk), .rst(rst), .frame_ready(fr_big), .rd_data(rd_data_big),
    .rd_addr(rd_addr_big), .busy(busy_big), .result_valid(rv_big), .color(color_big),
    .cnt_r(cnt_r_big), .cnt_g(cnt_g_big), .cnt_b(cnt_b_big)
  );

  always @(posedge clk) begin
    rd_data     <= mem_s[rd_addr];
    rd_data_big <= mem_b[rd_addr_big];
  end

  // Index inside the 8x6 window, or -1 outside it
  function automatic int win_idx(input int x, input int y);
    if (x >= 4 && x <= 11 && y >= 3 && y <= 8) return (y - 3) * 8 + (x - 4);
    return -1;
  endfunction

  task automatic run_scan(output int lat);
    @(negedge clk) frame_ready = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (result_valid !== 1'b1 && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_ready = 1'b0; fr_big = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rd_addr !== 8'd0) begin miscompares++; $display("FAIL reset rd_addr got %0d want 0", rd_addr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", busy); end
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL reset result_valid got %b want 0", result_valid); end
    vectors++; if (color !== 2'b00) begin miscompares++; $display("FAIL reset color got %b want 00", color); end
    vectors++; if ({cnt_r, cnt_g, cnt_b} !== 24'd0) begin miscompares++; $display("FAIL reset counts got %0d/%0d/%0d want 0/0/0", cnt_r, cnt_g, cnt_b); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_all_red();
    int lat;
    for (int i = 0; i < S_N; i++) mem_s[i] = PIX_R;
    run_scan(lat);
    vectors++; if (lat !== S_LAT) begin miscompares++; $display("FAIL all_red latency got %0d want %0d", lat, S_LAT); end
    vectors++; if (cnt_r !== 8'd48) begin miscompares++; $display("FAIL all_red cnt_r got %0d want 48", cnt_r); end
    vectors++; if (cnt_g !== 8'd0 || cnt_b !== 8'd0) begin miscompares++; $display("FAIL all_red cnt_g/b got %0d/%0d want 0/0", cnt_g, cnt_b); end
    vectors++; if (color !== COL_RED) begin miscompares++; $display("FAIL all_red color got %b want 01", color); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL all_red busy got %b want 0", busy); end
    vectors++; if (rd_addr !== 8'(S_N - 1)) begin miscompares++; $display("FAIL all_red rd_addr hold got %0d want %0d", rd_addr, S_N - 1); end
    @(posedge clk); #1;
    vectors++; if (result_valid !== 1'b0) begin miscompares++; $display("FAIL all_red pulse width got %b want 0", result_valid); end
    @(negedge clk) frame_ready = 1'b0;
  endtask

  task automatic test_window_mask();
    int lat;
    for (int y = 0; y < S_H; y++)
      for (int x = 0; x < S_W; x++)
        mem_s[y * S_W + x] = (win_idx(x, y) >= 0) ? PIX_G : PIX_B;
    run_scan(lat);
    vectors++; if (lat !== S_LAT) begin miscompares++; $display("FAIL mask latency got %0d want %0d", lat, S_LAT); end
    vectors++; if (cnt_g !== 8'd48) begin miscompares++; $display("FAIL mask cnt_g got %0d want 48", cnt_g); end
    vectors++; if (cnt_b !== 8'd0 || cnt_r !== 8'd0) begin miscompares++; $display("FAIL mask cnt_b/r got %0d/%0d want 0/0", cnt_b, cnt_r); end
    vectors++; if (color !== COL_GREEN) begin miscompares++; $display("FAIL mask color got %b want 10", color); end
    @(negedge clk) frame_ready = 1'b0;
  endtask

  task automatic test_threshold();
    int lat, w;
    for (int y = 0; y < S_H; y++)
      for (int x = 0; x < S_W; x++) begin
        w = win_idx(x, y);
        mem_s[y * S_W + x] = (w >= 0 && w < 12) ? PIX_B : (w >= 12 && w < 23) ? PIX_R : 3'b000;
      end
    run_scan(lat);
    vectors++; if (cnt_b !== 8'd12 || cnt_r !== 8'd11) begin miscompares++; $display("FAIL thresh_at cnt_b/r got %0d/%0d want 12/11", cnt_b, cnt_r); end
    vectors++; if (color !== COL_BLUE) begin miscompares++; $display("FAIL thresh_at color got %b want 11", color); end
    @(negedge clk) frame_ready = 1'b0;
    for (int y = 0; y < S_H; y++)
      for (int x = 0; x < S_W; x++) begin
        w = win_idx(x, y);
        mem_s[y * S_W + x] = (w >= 0 && w < 11) ? PIX_B : (w >= 11 && w < 22) ? PIX_R : 3'b000;
      end
    run_scan(lat);
    vectors++; if (cnt_b !== 8'd11 || cnt_r !== 8'd11) begin miscompares++; $display("FAIL thresh_below cnt_b/r got %0d/%0d want 11/11", cnt_b, cnt_r); end
    vectors++; if (color !== COL_NONE) begin miscompares++; $display("FAIL thresh_below color got %b want 00", color); end
    @(negedge clk) frame_ready = 1'b0;
  endtask

  task automatic test_tie();
    int lat, w;
    for (int y = 0; y < S_H; y++)
      for (int x = 0; x < S_W; x++) begin
        w = win_idx(x, y);
        mem_s[y * S_W + x] = (w >= 0 && w < 20) ? PIX_R : (w >= 20 && w < 40) ? PIX_G : 3'b111;
      end
    mem_s[0] = 3'b110;
    run_scan(lat);
    vectors++; if (cnt_r !== 8'd20 || cnt_g !== 8'd20) begin miscompares++; $display("FAIL tie cnt_r/g got %0d/%0d want 20/20", cnt_r, cnt_g); end
    vectors++; if (cnt_b !== 8'd0) begin miscompares++; $display("FAIL tie cnt_b got %0d want 0", cnt_b); end
    vectors++; if (color !== COL_RED) begin miscompares++; $display("FAIL tie color got %b want 01", color); end
    @(negedge clk) frame_ready = 1'b0;
  endtask

  task automatic test_retrigger();
    int pulses, lat;
    for (int i = 0; i < S_N; i++) mem_s[i] = PIX_B;
    @(negedge clk) frame_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2 * S_LAT + 20; c++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL held_high pulses got %0d want 1", pulses); end
    vectors++; if (color !== COL_BLUE || cnt_b !== 8'd48) begin miscompares++; $display("FAIL held_high color/cnt_b got %b/%0d want 11/48", color, cnt_b); end
    @(negedge clk) frame_ready = 1'b0;
    @(negedge clk) frame_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_scan busy got %b want 1", busy); end
    @(negedge clk) frame_ready = 1'b0;
    @(negedge clk) frame_ready = 1'b1;
    pulses = 0;
    for (int c = 0; c < 2 * S_LAT; c++) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL mid_scan_edge pulses got %0d want 1", pulses); end
    @(negedge clk) frame_ready = 1'b0;
    for (int i = 0; i < S_N; i++) mem_s[i] = PIX_G;
    run_scan(lat);
    vectors++; if (lat !== S_LAT) begin miscompares++; $display("FAIL second_scan latency got %0d want %0d", lat, S_LAT); end
    vectors++; if (color !== COL_GREEN || cnt_g !== 8'd48) begin miscompares++; $display("FAIL second_scan color/cnt_g got %b/%0d want 10/48", color, cnt_g); end
    @(negedge clk) frame_ready = 1'b0;
  endtask

  task automatic test_rst_mid_scan();
    int n, lat;
    for (int i = 0; i < S_N; i++) mem_s[i] = PIX_R;
    @(negedge clk) frame_ready = 1'b1;
    n = 0;
    while (rd_addr !== 8'd100 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++; if (rd_addr !== 8'd100) begin miscompares++; $display("FAIL rst_mid reach addr got %0d want 100", rd_addr); end
    rst = 1'b1;
    #1;
    vectors++; if (rd_addr !== 8'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid addr/busy got %0d/%b want 0/0", rd_addr, busy); end
    vectors++; if ({cnt_r, cnt_g, cnt_b} !== 24'd0 || color !== 2'b00) begin miscompares++; $display("FAIL rst_mid counts/color got %0d/%0d/%0d/%b want 0/0/0/00", cnt_r, cnt_g, cnt_b, color); end
    @(negedge clk) frame_ready = 1'b0;
    @(negedge clk) rst = 1'b0;
    run_scan(lat);
    vectors++; if (lat !== S_LAT) begin miscompares++; $display("FAIL rst_rescan latency got %0d want %0d", lat, S_LAT); end
    vectors++; if (cnt_r !== 8'd48 || color !== COL_RED) begin miscompares++; $display("FAIL rst_rescan cnt_r/color got %0d/%b want 48/01", cnt_r, color); end
    @(negedge clk) frame_ready = 1'b0;
  endtask

  task automatic test_full_qcif();
    int lat;
    for (int i = 0; i < B_N; i++) mem_b[i] = PIX_R;
    @(negedge clk) fr_big = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (rv_big !== 1'b1 && lat < 30000) begin
      @(posedge clk); #1;
      lat++;
    end
    vectors++; if (lat !== 25346) begin miscompares++; $display("FAIL qcif latency got %0d want 25346", lat); end
    vectors++; if (cnt_r_big !== 15'd6400) begin miscompares++; $display("FAIL qcif cnt_r got %0d want 6400", cnt_r_big); end
    vectors++; if (cnt_g_big !== 15'd0 || cnt_b_big !== 15'd0) begin miscompares++; $display("FAIL qcif cnt_g/b got %0d/%0d want 0/0", cnt_g_big, cnt_b_big); end
    vectors++; if (color_big !== COL_RED) begin miscompares++; $display("FAIL qcif color got %b want 01", color_big); end
    vectors++; if (rd_addr_big !== 15'd25343) begin miscompares++; $display("FAIL qcif rd_addr hold got %0d want 25343", rd_addr_big); end
    @(negedge clk) fr_big = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < S_N; i++) mem_s[i] = 3'b000;
    for (int i = 0; i < B_N; i++) mem_b[i] = 3'b000;
    test_reset();
    test_all_red();
    test_window_mask();
    test_threshold();
    test_tie();
    test_retrigger();
    test_rst_mid_scan();
    test_full_qcif();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frame_color_classifier.md
Name: frame_color_classifier

Overview:
- Consumes the 3-bit-per-pixel QCIF frame buffer (176x144 = 25344 words, R/G/B one bit each) written by the camera capture stage.
- On each rising edge of the capture stage's frame-complete flag, scans the buffer read port once and counts pure-red, pure-green and pure-blue pixels inside a programmable window.
- Reports the dominant colour to the vehicle control logic, which uses it to drive car_stop.

Parameters:
- AW, 15, buffer address width.
- IMG_W, 176, pixels per row.
- IMG_H, 144, rows per frame.
- WIN_X0, 48, first counted column (inclusive).
- WIN_X1, 127, last counted column (inclusive).
- WIN_Y0, 32, first counted row (inclusive).
- WIN_Y1, 111, last counted row (inclusive).
- THRESH, 1600, minimum winning count for a valid colour.

Ports:
- clk, input, 1, system clock; buffer read port is synchronous to it.
- rst, input, 1, asynchronous active-high reset.
- frame_ready, input, 1, level from capture stage; high while the buffer holds a complete frame.
- rd_data, input, 3, buffer read data; valid one clk after rd_addr.
- rd_addr, output, AW, buffer read address.
- busy, output, 1, high from scan start through DECIDE.
- result_valid, output, 1, one-cycle pulse when color/counts update.
- color, output, 2, 00 none, 01 red, 10 green, 11 blue.
- cnt_r / cnt_g / cnt_b, output, AW each, counts of the last completed scan.

Behaviour:
- Reset values: rd_addr=0, busy=0, result_valid=0, color=00, all counts 0, state IDLE, frame_ready edge register=0.
- frame_ready is registered once; start = frame_ready & ~frame_ready_q.
- A level held high never retriggers; the next scan needs a low-then-high transition.
- IDLE:
  - On start, clear the internal accumulators, rd_addr=0, col=0, row=0, busy=1, go to SCAN.
- SCAN:
  - rd_addr increments every cycle.
  - col/row track the issued address: col wraps IMG_W-1 -> 0 and increments row.
  - The issued address's (in_window) flag is delayed one cycle to align with rd_data.
  - After issuing address IMG_W*IMG_H-1 (25343), go to DRAIN.
  - rd_addr holds 25343; it never reaches 25344.
- DRAIN: 1 cycle; accumulates the data for the final address, then go to DECIDE.
- Accumulate rule, applied only when the aligned in_window flag=1:
  - 3'b100 increments acc_r; 3'b010 increments acc_g; 3'b001 increments acc_b.
  - All other codes (000, mixed) are ignored.
  - Accumulators saturate at 2^AW-1 and never wrap.
- DECIDE, 1 cycle:
  - Copy accumulators to cnt_r/g/b.
  - max = largest count; ties resolve red > green > blue.
  - color = code of max if max >= THRESH, else 00.
  - result_valid=1 for this cycle only; busy=0; go to IDLE.
- Scan latency: start edge to result_valid = 25344 + 2 cycles after entering SCAN.
- frame_ready falling during SCAN: the scan continues to completion. The capture stage does not rewrite the buffer while its flag is low mid-scan, so the result stands.
- Start edge during SCAN/DRAIN/DECIDE: ignored, not queued.
- rst mid-scan: immediate return to reset values; previous counts are lost.
- Window bounds are compared as full integers; WIN_X1 < WIN_X0 yields an empty window and color 00.

Decomposition:
- Shared package holds:
  - colour codes COL_NONE/RED/GREEN/BLUE (2-bit);
  - pixel codes PIX_R=3'b100, PIX_G=3'b010, PIX_B=3'b001;
  - QCIF constants 176/144/25344;
  - FSM state encoding IDLE, SCAN, DRAIN, DECIDE.
- One natural sub-module, pixel_raster_counter: the col/row/address generator with window flag and end-of-frame strobe. It is reusable by other buffer readers.

Test Plan:
- Buffer model all 3'b100, frame_ready 0->1 -> result_valid once after 25346 cycles, cnt_r=6400, cnt_g=cnt_b=0, color=01.
- Buffer green inside window, blue outside -> cnt_g=6400, cnt_b=0, color=10; confirms window masking and one-cycle data alignment at row/column edges (x=47/48, x=127/128).
- Window with 1600 blue and 1599 red, rest 000 -> color=11. Then 1599 blue and 1599 red -> color=00 (below THRESH).
- Tie of 3000 red and 3000 green, rest 3'b111 -> color=01, mixed codes uncounted.
- frame_ready held high for two scan lengths -> exactly one result_valid. A low-high pulse during SCAN -> ignored. A later low-high in IDLE -> second scan.
- rst asserted at scan address 10000 -> rd_addr=0, busy=0, counts=0 asynchronously. A fresh start edge then -> correct full result.
